elink_prbs_checker: RTL and testbench
=====================================

Name: elink_prbs_checker

Overview:
Parametrised multi-link PRBS-7 receive checker for e-link bit-error-rate testing. It replaces the fixed single-pattern, fixed-delay compare with independent per-link self-seeding, a lock state machine, saturating per-link counters and a registered readout mux. It sits after the e-link deserialiser in the clock domain of the recovered 40 MHz frame clock.

Parameters:
NLINKS, 14, number of e-links checked (1..32)
LINK_W, 8, bits per link per frame (>= 8)
CNT_W, 32, counter width
LOCK_FRAMES, 16, consecutive good frames required to declare lock (>= 1)
UNLOCK_ERRS, 4, consecutive errored frames that drop lock (>= 1)
LINK_MASK, all ones (NLINKS bits), 1 = link checked, 0 = link ignored

Ports:
clock  in  1  frame clock; all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
rx_valid  in  1  qualifies rx_data for one frame
rx_data  in  NLINKS*LINK_W  link i occupies [i*LINK_W +: LINK_W]; bit LINK_W-1 is the earliest bit
cnt_clear  in  1  synchronous clear of all counters
rd_link  in  5  link index for readout
rd_type  in  2  0 good frames, 1 error frames, 2 bit errors, 3 status
rd_data  out  CNT_W  registered readout
lock  out  NLINKS  per-link locked flag
err_pulse  out  NLINKS  one-cycle pulse per errored frame while locked

Behaviour:
- PRBS-7: s[n] = s[n-6] ^ s[n-7]. Each link has a 7-bit predictor state; expected frame = next LINK_W bits generated from that state.
- Per-link FSM, advancing only on rx_valid=1 for enabled links:
  - HUNT: state <= last 7 bits of rx frame; go to LOCKING with good_run=0.
  - LOCKING: compare rx to expected. Match: good_run+1, and at LOCK_FRAMES go to LOCKED. Mismatch: go to HUNT. State reseeds from rx each frame.
  - LOCKED: state advances from the expected frame, not rx, so errors do not propagate. Match: good counter +1, bad_run=0. Mismatch: error counter +1, err_pulse, bad_run+1; at UNLOCK_ERRS go to HUNT. The triggering frame is counted.
- rx_valid=0: FSM, counters and predictor hold.
- lock, err_pulse and counters update on the cycle after the rx frame is sampled (1-cycle latency).
- Counters saturate at 2^CNT_W-1 and never wrap.
- cnt_clear takes priority over a same-cycle increment and does not affect FSM state.
- rd_data is registered: it reflects rd_link/rd_type from the previous cycle. rd_link >= NLINKS returns 0.
- Status word (rd_type=3): bit0 = lock; bits[2:1] = FSM state (0 HUNT, 1 LOCKING, 2 LOCKED); remaining bits 0.
- LINK_MASK bit 0: link held in HUNT, lock=0, err_pulse=0, counters remain 0.
- Reset values: all counters 0, FSMs in HUNT, lock=0, err_pulse=0, rd_data=0. Reset asserted mid-lock returns to HUNT immediately (asynchronous).
- Stimulus with all-zero data never locks: a zero state predicts zeros but is rejected as an illegal seed, so the link stays in HUNT.

Optional Feature:
BIT_ERR_COUNT_EN
- Defined: per-link saturating bit-error counter, incremented in LOCKED by the popcount of (rx ^ expected). Saturation is clamped when the add would overflow. Readable at rd_type=2.
- Undefined: counter not instantiated; rd_type=2 returns 0.

Test Plan:
- Clean PRBS-7 on all 14 links, rx_valid=1 every cycle, defaults -> lock rises on all links 17 cycles after the first valid frame; error count 0; good count reads 100 after 100 further frames.
- Single bit flip on link 3 in one locked frame -> err_pulse[3] for exactly one cycle; link 3 error count = 1; lock stays 1; other links unaffected; bit-error count = 1 with the macro defined.
- 4 consecutive corrupted frames on link 5 -> lock[5] drops on the 4th; error count = 4; clean data relocks after 17 frames.
- LINK_MASK=14'h3FFE, link 0 fed garbage -> lock[0]=0, link 0 counters read 0, err_pulse[0] never asserts.
- Force link 2 error count to near saturation (CNT_W=4), inject 20 errors -> reads 15; cnt_clear in the same cycle as an error -> reads 0.
- Reset asserted mid-stream while locked -> lock=0 and rd_data=0 without a clock edge; after release, relock takes 17 frames.

Source files
------------

// File: rtl/elink_prbs_checker.sv
// Multi-link PRBS-7 receive checker: per-link self-seeding lock FSM and saturating counters.
// Optional per-link bit-error counter enabled by defining BIT_ERR_COUNT_EN.
module elink_prbs_checker #(
    parameter int                NLINKS      = 14,
    parameter int                LINK_W      = 8,
    parameter int                CNT_W       = 32,
    parameter int                LOCK_FRAMES = 16,
    parameter int                UNLOCK_ERRS = 4,
    parameter logic [NLINKS-1:0] LINK_MASK   = '1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     rx_valid,
    input  logic [NLINKS*LINK_W-1:0] rx_data,
    input  logic                     cnt_clear,
    input  logic [4:0]               rd_link,
    input  logic [1:0]               rd_type,
    output logic [CNT_W-1:0]         rd_data,
    output logic [NLINKS-1:0]        lock,
    output logic [NLINKS-1:0]        err_pulse
);

    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam int BW = $clog2(UNLOCK_ERRS + 1);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LOCKING = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Expected frame (low LINK_W bits) and the predictor state after it (top 7 bits).
    // Predictor bit 0 is the most recent bit; the frame MSB is the earliest bit.
    function automatic logic [LINK_W+6:0] prbs_gen(input logic [6:0] seed);
        logic [6:0]        st;
        logic [LINK_W-1:0] fr;
        logic              b;
        st = seed;
        fr = '0;
        for (int k = 0; k < LINK_W; k++) begin
            b = st[5] ^ st[6];
            fr[LINK_W-1-k] = b;
            st = {st[5:0], b};
        end
        return {st, fr};
    endfunction

`ifdef BIT_ERR_COUNT_EN
    localparam int PW = $clog2(LINK_W + 1);

    function automatic logic [PW-1:0] popcnt(input logic [LINK_W-1:0] v);
        logic [PW-1:0] c;
        c = '0;
        for (int k = 0; k < LINK_W; k++) begin
            c = c + PW'(v[k]);
        end
        return c;
    endfunction
`endif

    // Readout sources padded to 32 entries so any rd_link value indexes safely.
    logic [CNT_W-1:0] w_good_a [32];
    logic [CNT_W-1:0] w_err_a  [32];
    logic [CNT_W-1:0] w_bit_a  [32];
    logic [CNT_W-1:0] w_stat_a [32];
    logic [CNT_W-1:0] w_rd;
    logic [CNT_W-1:0] r_rd_data;

    for (genvar i = 0; i < 32; i++) begin : g_link
        if (i < NLINKS) begin : g_on
            state_t            r_state;
            state_t            w_state_nx;
            logic [6:0]        r_pred;
            logic [6:0]        w_pred_nx;
            logic [GW-1:0]     r_good_run;
            logic [GW-1:0]     w_good_run_nx;
            logic [BW-1:0]     r_bad_run;
            logic [BW-1:0]     w_bad_run_nx;
            logic              r_lock;
            logic              r_err;
            logic              w_inc_good;
            logic              w_inc_err;
            logic [CNT_W-1:0]  r_good_cnt;
            logic [CNT_W-1:0]  r_err_cnt;
            logic [LINK_W-1:0] w_rx;
            logic [LINK_W-1:0] w_exp;
            logic [6:0]        w_exp_pred;
            logic              w_en;
            logic              w_match;

            assign w_rx                = rx_data[i*LINK_W +: LINK_W];
            assign {w_exp_pred, w_exp} = prbs_gen(r_pred);
            assign w_en                = rx_valid & LINK_MASK[i];
            assign w_match             = (w_rx == w_exp);

            // Next-state logic: hunt for a nonzero seed, qualify, then free-run the predictor.
            always_comb begin
                w_state_nx    = r_state;
                w_pred_nx     = r_pred;
                w_good_run_nx = r_good_run;
                w_bad_run_nx  = r_bad_run;
                w_inc_good    = 1'b0;
                w_inc_err     = 1'b0;
                if (w_en) begin
                    case (r_state)
                        HUNT: begin
                            if (|w_rx[6:0]) begin
                                w_state_nx    = LOCKING;
                                w_pred_nx     = w_rx[6:0];
                                w_good_run_nx = '0;
                            end
                        end
                        LOCKING: begin
                            w_pred_nx = w_rx[6:0];
                            if (!w_match) begin
                                w_state_nx = HUNT;
                            end else if (r_good_run == GW'(LOCK_FRAMES - 1)) begin
                                w_state_nx    = LOCKED;
                                w_good_run_nx = '0;
                                w_bad_run_nx  = '0;
                            end else begin
                                w_good_run_nx = r_good_run + GW'(1);
                            end
                        end
                        LOCKED: begin
                            w_pred_nx = w_exp_pred;
                            if (w_match) begin
                                w_inc_good   = 1'b1;
                                w_bad_run_nx = '0;
                            end else begin
                                w_inc_err = 1'b1;
                                if (r_bad_run == BW'(UNLOCK_ERRS - 1)) begin
                                    w_state_nx   = HUNT;
                                    w_bad_run_nx = '0;
                                end else begin
                                    w_bad_run_nx = r_bad_run + BW'(1);
                                end
                            end
                        end
                        default: w_state_nx = HUNT;
                    endcase
                end
            end

            // FSM, predictor and lock/error flag registers.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_state    <= HUNT;
                    r_pred     <= '0;
                    r_good_run <= '0;
                    r_bad_run  <= '0;
                    r_lock     <= 1'b0;
                    r_err      <= 1'b0;
                end else begin
                    r_state    <= w_state_nx;
                    r_pred     <= w_pred_nx;
                    r_good_run <= w_good_run_nx;
                    r_bad_run  <= w_bad_run_nx;
                    r_lock     <= (w_state_nx == LOCKED);
                    r_err      <= w_inc_err;
                end
            end

            // Saturating good/error frame counters; clear wins over increment.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_good_cnt <= '0;
                    r_err_cnt  <= '0;
                end else if (cnt_clear) begin
                    r_good_cnt <= '0;
                    r_err_cnt  <= '0;
                end else begin
                    if (w_inc_good && !(&r_good_cnt)) begin
                        r_good_cnt <= r_good_cnt + CNT_W'(1);
                    end
                    if (w_inc_err && !(&r_err_cnt)) begin
                        r_err_cnt <= r_err_cnt + CNT_W'(1);
                    end
                end
            end

`ifdef BIT_ERR_COUNT_EN
            logic [CNT_W-1:0] r_bit_cnt;
            logic [CNT_W:0]   w_bit_sum;
            logic             w_bit_add;

            assign w_bit_add = w_en && (r_state == LOCKED);
            assign w_bit_sum = {1'b0, r_bit_cnt} + (CNT_W+1)'(popcnt(w_rx ^ w_exp));

            // Saturating bit-error counter, clamped when the add overflows.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_bit_cnt <= '0;
                end else if (cnt_clear) begin
                    r_bit_cnt <= '0;
                end else if (w_bit_add) begin
                    r_bit_cnt <= w_bit_sum[CNT_W] ? '1 : w_bit_sum[CNT_W-1:0];
                end
            end

            assign w_bit_a[i] = r_bit_cnt;
`else
            assign w_bit_a[i] = '0;
`endif

            // Status word: bit0 lock, bits[2:1] FSM state.
            always_comb begin
                w_stat_a[i]      = '0;
                w_stat_a[i][2:0] = {r_state, r_lock};
            end

            assign w_good_a[i]  = r_good_cnt;
            assign w_err_a[i]   = r_err_cnt;
            assign lock[i]      = r_lock;
            assign err_pulse[i] = r_err;
        end else begin : g_off
            assign w_good_a[i] = '0;
            assign w_err_a[i]  = '0;
            assign w_bit_a[i]  = '0;
            assign w_stat_a[i] = '0;
        end
    end

    // Readout select.
    always_comb begin
        w_rd = '0;
        case (rd_type)
            2'd0:    w_rd = w_good_a[rd_link];
            2'd1:    w_rd = w_err_a[rd_link];
            2'd2:    w_rd = w_bit_a[rd_link];
            default: w_rd = w_stat_a[rd_link];
        endcase
    end

    // Registered readout.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd;
        end
    end

    assign rd_data = r_rd_data;

endmodule

// File: tb/tb_elink_prbs_checker.sv
// Directed bench for elink_prbs_checker: default instance plus a CNT_W=4,
// link-0-masked instance sharing the same stimulus.
module tb_elink_prbs_checker;

    localparam int NL = 14;
    localparam int LW = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic              rx_valid;
    logic [NL*LW-1:0]  rx_data;
    logic              cnt_clear;
    logic [4:0]        rd_link;
    logic [1:0]        rd_type;
    logic [31:0]       rd_data;
    logic [3:0]        rd_data2;
    logic [NL-1:0]     lock, lock2;
    logic [NL-1:0]     errp, errp2;

    int checks = 0;
    int errors = 0;

    logic [6:0]        gen [NL];
    logic [NL*LW-1:0]  corrupt;

    elink_prbs_checker dut (
        .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .cnt_clear(cnt_clear), .rd_link(rd_link), .rd_type(rd_type),
        .rd_data(rd_data), .lock(lock), .err_pulse(errp)
    );

    elink_prbs_checker #(.CNT_W(4), .LINK_MASK(14'h3FFE)) dut2 (
        .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .cnt_clear(cnt_clear), .rd_link(rd_link), .rd_type(rd_type),
        .rd_data(rd_data2), .lock(lock2), .err_pulse(errp2)
    );

    always #5 clock = ~clock;

    task automatic gen_frame(output logic [NL*LW-1:0] f);
        logic b;
        f = '0;
        for (int i = 0; i < NL; i++) begin
            for (int k = LW - 1; k >= 0; k--) begin
                b = gen[i][6] ^ gen[i][5];
                f[i*LW+k] = b;
                gen[i] = {gen[i][5:0], b};
            end
        end
    endtask

    // One frame slot: drive at negedge, return at the next negedge.
    task automatic step(input logic v);
        logic [NL*LW-1:0] f;
        if (v) begin
            gen_frame(f);
            rx_data = f ^ corrupt;
        end
        rx_valid = v;
        @(negedge clock);
    endtask

    task automatic err_step(input logic [NL*LW-1:0] m);
        corrupt = m;
        step(1'b1);
        corrupt = '0;
    endtask

    task automatic rd(input int link, input int typ,
                      output logic [31:0] v1, output logic [3:0] v2);
        rx_valid = 1'b0;
        rd_link  = 5'(link);
        rd_type  = 2'(typ);
        @(negedge clock);
        v1 = rd_data;
        v2 = rd_data2;
    endtask

    task automatic do_reset;
        reset     = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = '0;
        cnt_clear = 1'b0;
        corrupt   = '0;
        rd_link   = '0;
        rd_type   = '0;
        for (int i = 0; i < NL; i++) gen[i] = 7'(i * 9 + 1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] a;
        logic [3:0]  b;
        do_reset();
        checks++;
        if (lock !== 14'h0 || errp !== 14'h0 || rd_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_outs lock=%h err=%h rd=%h want 0", lock, errp, rd_data);
        end
        rd(4, 3, a, b);
        checks++;
        if (a !== 32'h0) begin
            errors++;
            $display("FAIL reset_status got %h want 0", a);
        end
    endtask

    task automatic test_lock;
        logic [31:0] a;
        logic [3:0]  b;
        do_reset();
        repeat (16) step(1'b1);
        checks++;
        if (lock !== 14'h0) begin
            errors++;
            $display("FAIL lock_early got %h want 0000", lock);
        end
        step(1'b1);
        checks++;
        if (lock !== 14'h3FFF) begin
            errors++;
            $display("FAIL lock_17 got %h want 3fff", lock);
        end
        checks++;
        if (lock2 !== 14'h3FFE) begin
            errors++;
            $display("FAIL lock_masked got %h want 3ffe", lock2);
        end
        repeat (100) step(1'b1);
        rd(7, 0, a, b);
        checks++;
        if (a !== 32'd100) begin
            errors++;
            $display("FAIL good_cnt got %0d want 100", a);
        end
        checks++;
        if (b !== 4'd15) begin
            errors++;
            $display("FAIL good_sat got %0d want 15", b);
        end
        rd(0, 1, a, b);
        checks++;
        if (a !== 32'd0) begin
            errors++;
            $display("FAIL err_clean got %0d want 0", a);
        end
        rd(7, 3, a, b);
        checks++;
        if (a !== 32'd5) begin
            errors++;
            $display("FAIL status_locked got %h want 5", a);
        end
        rd(20, 0, a, b);
        checks++;
        if (a !== 32'd0) begin
            errors++;
            $display("FAIL rd_oob got %0d want 0", a);
        end
    endtask

    task automatic test_single_flip;
        logic [31:0] a;
        logic [3:0]  b;
        logic [NL*LW-1:0] m;
        m = '0;
        m[3*LW] = 1'b1;
        err_step(m);
        checks++;
        if (errp !== 14'h0008) begin
            errors++;
            $display("FAIL flip_pulse got %h want 0008", errp);
        end
        step(1'b1);
        checks++;
        if (errp !== 14'h0 || lock !== 14'h3FFF) begin
            errors++;
            $display("FAIL flip_after err=%h lock=%h want 0000/3fff", errp, lock);
        end
        rd(3, 1, a, b);
        checks++;
        if (a !== 32'd1) begin
            errors++;
            $display("FAIL flip_errcnt got %0d want 1", a);
        end
        rd(4, 1, a, b);
        checks++;
        if (a !== 32'd0) begin
            errors++;
            $display("FAIL flip_other got %0d want 0", a);
        end
        rd(3, 2, a, b);
        checks++;
`ifdef BIT_ERR_COUNT_EN
        if (a !== 32'd1) begin
            errors++;
            $display("FAIL flip_bitcnt got %0d want 1", a);
        end
`else
        if (a !== 32'd0) begin
            errors++;
            $display("FAIL flip_bitcnt got %0d want 0", a);
        end
`endif
    endtask

    task automatic test_unlock;
        logic [31:0] a;
        logic [3:0]  b;
        logic [NL*LW-1:0] m;
        m = '0;
        m[5*LW] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            err_step(m);
            checks++;
            if (lock !== 14'h3FFF) begin
                errors++;
                $display("FAIL unlock_hold%0d got %h want 3fff", k, lock);
            end
        end
        err_step(m);
        checks++;
        if (lock !== 14'h3FDF || errp !== 14'h0020) begin
            errors++;
            $display("FAIL unlock_drop lock=%h err=%h want 3fdf/0020", lock, errp);
        end
        rd(5, 1, a, b);
        checks++;
        if (a !== 32'd4) begin
            errors++;
            $display("FAIL unlock_errcnt got %0d want 4", a);
        end
        repeat (16) step(1'b1);
        checks++;
        if (lock !== 14'h3FDF) begin
            errors++;
            $display("FAIL relock_early got %h want 3fdf", lock);
        end
        step(1'b1);
        checks++;
        if (lock !== 14'h3FFF) begin
            errors++;
            $display("FAIL relock got %h want 3fff", lock);
        end
    endtask

    task automatic test_mask;
        logic [31:0] a;
        logic [3:0]  b;
        logic        seen;
        logic [NL*LW-1:0] m;
        do_reset();
        repeat (20) step(1'b1);
        checks++;
        if (lock !== 14'h3FFF || lock2 !== 14'h3FFE) begin
            errors++;
            $display("FAIL mask_lock lock=%h lock2=%h want 3fff/3ffe", lock, lock2);
        end
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            m = '0;
            m[7:0] = 8'($urandom_range(1, 255));
            err_step(m);
            if (errp2[0]) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL mask_pulse got %b want 0", seen);
        end
        for (int t = 0; t < 4; t++) begin
            if (t == 2) continue;
            rd(0, t, a, b);
            checks++;
            if (b !== 4'd0) begin
                errors++;
                $display("FAIL mask_rd%0d got %0d want 0", t, b);
            end
        end
        rd(1, 0, a, b);
        checks++;
        if (b !== 4'd13) begin
            errors++;
            $display("FAIL mask_neighbour got %0d want 13", b);
        end
    endtask

    task automatic test_saturation;
        logic [31:0] a;
        logic [3:0]  b;
        logic [NL*LW-1:0] m;
        do_reset();
        repeat (17) step(1'b1);
        m = '0;
        m[2*LW] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            err_step(m);
            step(1'b1);
        end
        rd(2, 1, a, b);
        checks++;
        if (a !== 32'd20 || b !== 4'd15) begin
            errors++;
            $display("FAIL sat_err got %0d/%0d want 20/15", a, b);
        end
        rd(2, 2, a, b);
        checks++;
`ifdef BIT_ERR_COUNT_EN
        if (a !== 32'd20 || b !== 4'd15) begin
            errors++;
            $display("FAIL sat_bit got %0d/%0d want 20/15", a, b);
        end
`else
        if (a !== 32'd0 || b !== 4'd0) begin
            errors++;
            $display("FAIL sat_bit got %0d/%0d want 0/0", a, b);
        end
`endif
        cnt_clear = 1'b1;
        err_step(m);
        cnt_clear = 1'b0;
        checks++;
        if (lock !== 14'h3FFF || errp !== 14'h0004) begin
            errors++;
            $display("FAIL clr_fsm lock=%h err=%h want 3fff/0004", lock, errp);
        end
        rd(2, 1, a, b);
        checks++;
        if (a !== 32'd0 || b !== 4'd0) begin
            errors++;
            $display("FAIL clr_err got %0d/%0d want 0/0", a, b);
        end
        rd(2, 0, a, b);
        checks++;
        if (a !== 32'd0) begin
            errors++;
            $display("FAIL clr_good got %0d want 0", a);
        end
    endtask

    task automatic test_reset_midstream;
        logic [31:0] a;
        logic [3:0]  b;
        rd(2, 3, a, b);
        checks++;
        if (a !== 32'd5) begin
            errors++;
            $display("FAIL pre_reset_status got %h want 5", a);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (lock !== 14'h0 || rd_data !== 32'h0 || errp !== 14'h0) begin
            errors++;
            $display("FAIL async_reset lock=%h rd=%h err=%h want 0", lock, rd_data, errp);
        end
        #1;
        reset = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step(1'b1);
            step(1'b0);
        end
        checks++;
        if (lock !== 14'h0) begin
            errors++;
            $display("FAIL gap_relock_early got %h want 0000", lock);
        end
        step(1'b1);
        checks++;
        if (lock !== 14'h3FFF) begin
            errors++;
            $display("FAIL gap_relock got %h want 3fff", lock);
        end
    endtask

    task automatic test_zero_data;
        logic [31:0] a;
        logic [3:0]  b;
        do_reset();
        rx_data  = '0;
        rx_valid = 1'b1;
        repeat (30) @(negedge clock);
        checks++;
        if (lock !== 14'h0) begin
            errors++;
            $display("FAIL zero_lock got %h want 0000", lock);
        end
        rd(9, 3, a, b);
        checks++;
        if (a !== 32'd0) begin
            errors++;
            $display("FAIL zero_status got %h want 0", a);
        end
    endtask

    initial begin
        reset     = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = '0;
        cnt_clear = 1'b0;
        rd_link   = '0;
        rd_type   = '0;
        corrupt   = '0;
        test_reset();
        test_lock();
        test_single_flip();
        test_unlock();
        test_mask();
        test_saturation();
        test_reset_midstream();
        test_zero_data();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
